// File: rtl/munoc_slave_write_depacketizer_pkg.sv
// Shared types and header-layout helpers for the slave write depacketizer.
// Header payload, LSB first: slave_id, master_id, tid, burst, size, len, addr.
package munoc_slave_write_depacketizer_pkg;

    typedef enum logic [1:0] {
        S_HEAD = 2'd0,
        S_DATA = 2'd1,
        S_DROP = 2'd2
    } state_e;

    localparam int BW_BURST = 2;
    localparam int BW_SIZE  = 3;
    localparam int BW_LEN   = 8;
    localparam int BW_BEATS = 9;

    function automatic int flit_payload_width(input int flit_data_w);
        return flit_data_w * 9 / 8;
    endfunction

    function automatic int hdr_width(input int node_w, input int tid_w, input int addr_w);
        return 2 * node_w + tid_w + BW_BURST + BW_SIZE + BW_LEN + addr_w;
    endfunction

    // Bit offset of the len field inside the header payload.
    function automatic int hdr_len_lsb(input int node_w, input int tid_w);
        return 2 * node_w + tid_w + BW_BURST + BW_SIZE;
    endfunction

endpackage

// File: rtl/munoc_sync_fifo.sv
// Single-clock FIFO with occupancy counter; dout is read straight from the
// storage registers, so a pushed entry becomes visible the cycle after the push.
module munoc_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] dout_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign dout_o  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop)
            count_d = count_q + 1'b1;
        else if (do_pop && !do_push)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem_q[wr_ptr_q] <= din_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/munoc_slave_write_depacketizer.sv
// Splits a slave-side NoC write flit stream into AXI AW and W channels,
// packing R data flits into each W beat and checking packet length.
module munoc_slave_write_depacketizer
    import munoc_slave_write_depacketizer_pkg::*;
#(
    parameter int BW_FLIT_DATA  = 64,
    parameter int BW_DATA       = 128,
    parameter int BW_ADDR       = 32,
    parameter int BW_TID        = 4,
    parameter int BW_NODE_ID    = 4,
    parameter int AW_FIFO_DEPTH = 2,
    parameter int W_FIFO_DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       link_fvalid,
    input  logic [BW_FLIT_DATA*9/8:0]  link_fdata,
    output logic                       link_fready,
    output logic                       awvalid,
    input  logic                       awready,
    output logic [BW_ADDR-1:0]         awaddr,
    output logic [7:0]                 awlen,
    output logic [2:0]                 awsize,
    output logic [1:0]                 awburst,
    output logic [BW_TID-1:0]          awid,
    output logic [BW_NODE_ID-1:0]      awmaster,
    output logic                       wvalid,
    input  logic                       wready,
    output logic [BW_DATA-1:0]         wdata,
    output logic [BW_DATA/8-1:0]       wstrb,
    output logic                       wlast,
    output logic                       err_pulse
);
    localparam int PW    = flit_payload_width(BW_FLIT_DATA);
    localparam int R     = BW_DATA / BW_FLIT_DATA;
    localparam int SW    = BW_FLIT_DATA / 8;
    localparam int BSW   = BW_DATA / 8;
    localparam int CW    = (R > 1) ? $clog2(R) : 1;
    localparam int HDR_W = hdr_width(BW_NODE_ID, BW_TID, BW_ADDR);
    localparam int AW_W  = HDR_W - BW_NODE_ID;
    localparam int W_W   = BW_DATA + BSW + 1;

    generate
        if (HDR_W > PW || R < 1 || (R & (R - 1)) != 0 || R * BW_FLIT_DATA != BW_DATA) begin : g_bad_cfg
            $error("munoc_slave_write_depacketizer: illegal parameter combination");
        end
    endgenerate

    state_e                state_q, state_d;
    logic [BW_BEATS-1:0]   beats_q, beats_d;
    logic [CW-1:0]         chunk_q, chunk_d;
    logic [BW_DATA-1:0]    asm_data_q, asm_data_d, asm_data_m;
    logic [BSW-1:0]        asm_strb_q, asm_strb_d, asm_strb_m;
    logic                  err_q, err_d;

    logic                  flit_last, flit_xfer, chunk_wr, beat_done, final_beat;
    logic [PW-1:0]         payload;
    logic [BW_LEN-1:0]     hdr_len;
    logic                  aw_push, aw_pop, aw_full, aw_empty;
    logic [AW_W-1:0]       aw_dout;
    logic                  w_push, w_pop, w_full, w_empty, w_last;
    logic [W_W-1:0]        w_din, w_dout;

    assign flit_last  = link_fdata[PW];
    assign payload    = link_fdata[PW-1:0];
    assign hdr_len    = payload[hdr_len_lsb(BW_NODE_ID, BW_TID) +: BW_LEN];
    assign flit_xfer  = link_fvalid & link_fready;
    assign chunk_wr   = flit_xfer & (state_q == S_DATA);
    assign beat_done  = (chunk_q == CW'(R - 1));
    assign final_beat = (beats_q == BW_BEATS'(1));

    // Merged view of the assembly register including the chunk arriving now,
    // so a completing beat can be pushed in the same cycle.
    generate
        for (genvar gi = 0; gi < R; gi++) begin : g_asm
            assign asm_data_m[gi*BW_FLIT_DATA +: BW_FLIT_DATA] =
                (chunk_wr && chunk_q == CW'(gi)) ? payload[BW_FLIT_DATA-1:0]
                                                 : asm_data_q[gi*BW_FLIT_DATA +: BW_FLIT_DATA];
            assign asm_strb_m[gi*SW +: SW] =
                (chunk_wr && chunk_q == CW'(gi)) ? payload[PW-1:BW_FLIT_DATA]
                                                 : asm_strb_q[gi*SW +: SW];
        end
    endgenerate

    assign w_last = flit_last | final_beat;
    assign w_din  = {w_last, asm_strb_m, asm_data_m};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_HEAD;
            beats_q    <= '0;
            chunk_q    <= '0;
            asm_data_q <= '0;
            asm_strb_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            beats_q    <= beats_d;
            chunk_q    <= chunk_d;
            asm_data_q <= asm_data_d;
            asm_strb_q <= asm_strb_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        beats_d    = beats_q;
        chunk_d    = chunk_q;
        asm_data_d = asm_data_q;
        asm_strb_d = asm_strb_q;
        err_d      = 1'b0;
        aw_push    = 1'b0;
        w_push     = 1'b0;
        case (state_q)
            S_HEAD: begin
                if (flit_xfer) begin
                    if (flit_last) begin
                        err_d = 1'b1;
                    end else begin
                        aw_push = 1'b1;
                        beats_d = {1'b0, hdr_len} + BW_BEATS'(1);
                        chunk_d = '0;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (flit_xfer) begin
                    asm_data_d = asm_data_m;
                    asm_strb_d = asm_strb_m;
                    chunk_d    = chunk_q + 1'b1;
                    if (beat_done || flit_last) begin
                        w_push     = 1'b1;
                        asm_strb_d = '0;
                        chunk_d    = '0;
                    end
                    if (beat_done)
                        beats_d = beats_q - BW_BEATS'(1);
                    if (flit_last) begin
                        state_d = S_HEAD;
                        err_d   = !(beat_done && final_beat);
                    end else if (beat_done && final_beat) begin
                        err_d   = 1'b1;
                        state_d = S_DROP;
                    end
                end
            end
            S_DROP: begin
                if (flit_xfer && flit_last)
                    state_d = S_HEAD;
            end
            default: state_d = S_HEAD;
        endcase
    end

    // Backpressure depends only on buffer fullness, never on a same-cycle pop.
    always_comb begin
        link_fready = 1'b0;
        if (!rst) begin
            case (state_q)
                S_HEAD:  link_fready = !aw_full;
                S_DATA:  link_fready = !w_full;
                default: link_fready = 1'b1;
            endcase
        end
    end

    munoc_sync_fifo #(.WIDTH(AW_W), .DEPTH(AW_FIFO_DEPTH)) u_aw_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (aw_push),
        .din_i   (payload[HDR_W-1:BW_NODE_ID]),
        .pop_i   (aw_pop),
        .full_o  (aw_full),
        .empty_o (aw_empty),
        .dout_o  (aw_dout)
    );

    munoc_sync_fifo #(.WIDTH(W_W), .DEPTH(W_FIFO_DEPTH)) u_w_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_push),
        .din_i   (w_din),
        .pop_i   (w_pop),
        .full_o  (w_full),
        .empty_o (w_empty),
        .dout_o  (w_dout)
    );

    assign awvalid   = !rst && !aw_empty;
    assign wvalid    = !rst && !w_empty;
    assign aw_pop    = awvalid & awready;
    assign w_pop     = wvalid & wready;
    assign {awaddr, awlen, awsize, awburst, awid, awmaster} = awvalid ? aw_dout : '0;
    assign {wlast, wstrb, wdata} = wvalid ? w_dout : '0;
    assign err_pulse = err_q;

endmodule

// File: tb/tb_munoc_slave_write_depacketizer.sv
// Scoreboard bench: directed packets push expected AW/W entries; monitors pop
// and compare on every AXI handshake. u0 runs R=2, u1 runs R=1.
module tb_munoc_slave_write_depacketizer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         fvalid0, fready0, awvalid0, awready0, wvalid0, wready0, wlast0, err0;
    logic [72:0]  fdata0;
    logic [31:0]  awaddr0;
    logic [7:0]   awlen0;
    logic [2:0]   awsize0;
    logic [1:0]   awburst0;
    logic [3:0]   awid0, awmaster0;
    logic [127:0] wdata0;
    logic [15:0]  wstrb0;

    logic         fvalid1, fready1, awvalid1, awready1, wvalid1, wready1, wlast1, err1;
    logic [72:0]  fdata1;
    logic [31:0]  awaddr1;
    logic [7:0]   awlen1;
    logic [2:0]   awsize1;
    logic [1:0]   awburst1;
    logic [3:0]   awid1, awmaster1;
    logic [63:0]  wdata1;
    logic [7:0]   wstrb1;

    munoc_slave_write_depacketizer #(.BW_DATA(128)) u0 (
        .clk(clk), .rst(rst), .link_fvalid(fvalid0), .link_fdata(fdata0), .link_fready(fready0),
        .awvalid(awvalid0), .awready(awready0), .awaddr(awaddr0), .awlen(awlen0), .awsize(awsize0),
        .awburst(awburst0), .awid(awid0), .awmaster(awmaster0), .wvalid(wvalid0), .wready(wready0),
        .wdata(wdata0), .wstrb(wstrb0), .wlast(wlast0), .err_pulse(err0)
    );

    munoc_slave_write_depacketizer #(.BW_DATA(64)) u1 (
        .clk(clk), .rst(rst), .link_fvalid(fvalid1), .link_fdata(fdata1), .link_fready(fready1),
        .awvalid(awvalid1), .awready(awready1), .awaddr(awaddr1), .awlen(awlen1), .awsize(awsize1),
        .awburst(awburst1), .awid(awid1), .awmaster(awmaster1), .wvalid(wvalid1), .wready(wready1),
        .wdata(wdata1), .wstrb(wstrb1), .wlast(wlast1), .err_pulse(err1)
    );

    logic [52:0]  exp_aw0[$], exp_aw1[$];
    logic [144:0] exp_w0[$];
    logic [72:0]  exp_w1[$];
    int n_cmp = 0;
    int n_bad = 0;
    int err_cnt0 = 0;
    int err_cnt1 = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [72:0] hdr(input logic [3:0] master, input logic [3:0] tid,
                                        input logic [1:0] burst, input logic [2:0] size,
                                        input logic [7:0] len, input logic [31:0] addr);
        logic [71:0] p;
        p = '0;
        p[56:0] = {addr, len, size, burst, tid, master, 4'h9};
        return {1'b0, p};
    endfunction

    function automatic logic [52:0] awx(input logic [3:0] master, input logic [3:0] tid,
                                        input logic [1:0] burst, input logic [2:0] size,
                                        input logic [7:0] len, input logic [31:0] addr);
        return {addr, len, size, burst, tid, master};
    endfunction

    function automatic logic [72:0] dat(input logic last, input logic [7:0] strb, input logic [63:0] d);
        return {last, strb, d};
    endfunction

    function automatic logic [127:0] bmask(input logic [15:0] s);
        logic [127:0] m;
        for (int i = 0; i < 16; i++) m[i*8 +: 8] = {8{s[i]}};
        return m;
    endfunction

    // Monitors: one compare per AXI handshake; data bytes with strb=0 are don't-care.
    always @(negedge clk) begin : mon0
        logic [144:0] e;
        logic [127:0] m;
        if (err0) err_cnt0++;
        if (awvalid0 && awready0) begin
            if (exp_aw0.size() == 0) chk("aw0_unexpected", 256'({awaddr0, awlen0}), 256'(1));
            else chk("aw0", 256'({awaddr0, awlen0, awsize0, awburst0, awid0, awmaster0}), 256'(exp_aw0.pop_front()));
        end
        if (wvalid0 && wready0) begin
            if (exp_w0.size() == 0) chk("w0_unexpected", 256'(wdata0), 256'(1));
            else begin
                e = exp_w0.pop_front();
                m = bmask(e[143:128]);
                chk("w0", 256'({wlast0, wstrb0, wdata0 & m}), 256'({e[144], e[143:128], e[127:0] & m}));
            end
        end
    end

    always @(negedge clk) begin : mon1
        logic [72:0]  e;
        logic [127:0] m;
        if (err1) err_cnt1++;
        if (awvalid1 && awready1) begin
            if (exp_aw1.size() == 0) chk("aw1_unexpected", 256'({awaddr1, awlen1}), 256'(1));
            else chk("aw1", 256'({awaddr1, awlen1, awsize1, awburst1, awid1, awmaster1}), 256'(exp_aw1.pop_front()));
        end
        if (wvalid1 && wready1) begin
            if (exp_w1.size() == 0) chk("w1_unexpected", 256'(wdata1), 256'(1));
            else begin
                e = exp_w1.pop_front();
                m = bmask({8'h00, e[71:64]});
                chk("w1", 256'({wlast1, wstrb1, wdata1 & m[63:0]}), 256'({e[72], e[71:64], e[63:0] & m[63:0]}));
            end
        end
    end

    task automatic send(input bit u, input logic [72:0] f);
        int n;
        n = 0;
        if (!u) begin fvalid0 = 1'b1; fdata0 = f; end
        else    begin fvalid1 = 1'b1; fdata1 = f; end
        @(negedge clk);
        while (!(u ? fready1 : fready0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (n >= 300) begin
            n_bad++;
            $display("FAIL send_timeout: flit %0h not accepted after %0d cycles, required accept", f, n);
        end
        @(posedge clk);
        #1;
        fvalid0 = 1'b0;
        fvalid1 = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_aw0.size() + exp_w0.size() + exp_aw1.size() + exp_w1.size()) != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        n_cmp++;
        if (n >= 500) begin
            n_bad++;
            $display("FAIL drain_timeout: pending aw0=%0d w0=%0d aw1=%0d w1=%0d, required 0",
                     exp_aw0.size(), exp_w0.size(), exp_aw1.size(), exp_w1.size());
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] tdat(input int i);
        return 64'hD200_0000_0000_0000 | 64'(i);
    endfunction

    function automatic logic [7:0] tstrb(input int i);
        return (i == 5) ? 8'h3c : 8'hff;
    endfunction

    initial begin
        fvalid0 = 1'b0; fdata0 = '0; awready0 = 1'b1; wready0 = 1'b1;
        fvalid1 = 1'b0; fdata1 = '0; awready1 = 1'b1; wready1 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_fready0", 256'(fready0), 256'(0));
        chk("rst_fready1", 256'(fready1), 256'(0));
        chk("rst_awvalid0", 256'(awvalid0), 256'(0));
        chk("rst_wvalid0", 256'(wvalid0), 256'(0));
        chk("rst_err0", 256'(err0), 256'(0));
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("idle_fready0", 256'(fready0), 256'(1));
        @(posedge clk); #1;

        // len=0: one beat {flit1,flit0} with wlast
        exp_aw0.push_back(awx(4'd5, 4'd2, 2'd1, 3'd3, 8'd0, 32'h0000_1000));
        exp_w0.push_back({1'b1, 16'hffff, 64'hBBBB_0000_0000_0002, 64'hAAAA_0000_0000_0001});
        send(0, hdr(4'd5, 4'd2, 2'd1, 3'd3, 8'd0, 32'h0000_1000));
        send(0, dat(1'b0, 8'hff, 64'hAAAA_0000_0000_0001));
        send(0, dat(1'b1, 8'hff, 64'hBBBB_0000_0000_0002));
        drain();
        chk("t1_err_cnt", 256'(err_cnt0), 256'(0));

        // len=4 with wready low: W fills after 4 beats (8 flits) and stalls the link
        wready0 = 1'b0;
        exp_aw0.push_back(awx(4'd1, 4'd7, 2'd1, 3'd3, 8'd4, 32'h0000_4000));
        for (int b = 0; b < 5; b++)
            exp_w0.push_back({(b == 4), tstrb(2*b+1), tstrb(2*b), tdat(2*b+1), tdat(2*b)});
        send(0, hdr(4'd1, 4'd7, 2'd1, 3'd3, 8'd4, 32'h0000_4000));
        for (int i = 0; i < 8; i++) send(0, dat(1'b0, tstrb(i), tdat(i)));
        fvalid0 = 1'b1; fdata0 = dat(1'b0, tstrb(8), tdat(8));
        repeat (3) @(negedge clk);
        chk("t2_wfull_fready", 256'(fready0), 256'(0));
        chk("t2_wvalid_held", 256'(wvalid0), 256'(1));
        @(posedge clk); #1;
        wready0 = 1'b1;
        send(0, dat(1'b0, tstrb(8), tdat(8)));
        send(0, dat(1'b1, tstrb(9), tdat(9)));
        drain();
        chk("t2_err_cnt", 256'(err_cnt0), 256'(0));

        // awready low: third header must wait; AW order preserved
        awready0 = 1'b0;
        for (int p = 0; p < 3; p++) begin
            exp_aw0.push_back(awx(4'(p), 4'(p+1), 2'd1, 3'd3, 8'd0, 32'h2000 + 32'(p*256)));
            exp_w0.push_back({1'b1, 16'hffff, tdat(20+2*p+1), tdat(20+2*p)});
        end
        for (int p = 0; p < 2; p++) begin
            send(0, hdr(4'(p), 4'(p+1), 2'd1, 3'd3, 8'd0, 32'h2000 + 32'(p*256)));
            send(0, dat(1'b0, 8'hff, tdat(20+2*p)));
            send(0, dat(1'b1, 8'hff, tdat(20+2*p+1)));
        end
        fvalid0 = 1'b1; fdata0 = hdr(4'd2, 4'd3, 2'd1, 3'd3, 8'd0, 32'h2200);
        repeat (3) @(negedge clk);
        chk("t3_awfull_fready", 256'(fready0), 256'(0));
        chk("t3_awvalid_held", 256'(awvalid0), 256'(1));
        @(posedge clk); #1;
        awready0 = 1'b1;
        send(0, hdr(4'd2, 4'd3, 2'd1, 3'd3, 8'd0, 32'h2200));
        send(0, dat(1'b0, 8'hff, tdat(24)));
        send(0, dat(1'b1, 8'hff, tdat(25)));
        drain();

        // len=1 ending early on the 3rd data flit: partial beat, one error, then a clean packet
        exp_aw0.push_back(awx(4'd3, 4'd4, 2'd1, 3'd3, 8'd1, 32'h0000_3000));
        exp_w0.push_back({1'b0, 16'hffff, tdat(41), tdat(40)});
        exp_w0.push_back({1'b1, 16'h00ff, 64'h0, tdat(42)});
        exp_aw0.push_back(awx(4'd6, 4'd8, 2'd2, 3'd2, 8'd0, 32'h0000_3100));
        exp_w0.push_back({1'b1, 16'hf00f, tdat(44), tdat(43)});
        send(0, hdr(4'd3, 4'd4, 2'd1, 3'd3, 8'd1, 32'h0000_3000));
        send(0, dat(1'b0, 8'hff, tdat(40)));
        send(0, dat(1'b0, 8'hff, tdat(41)));
        send(0, dat(1'b1, 8'hff, tdat(42)));
        send(0, hdr(4'd6, 4'd8, 2'd2, 3'd2, 8'd0, 32'h0000_3100));
        send(0, dat(1'b0, 8'h0f, tdat(43)));
        send(0, dat(1'b1, 8'hf0, tdat(44)));
        drain();
        chk("t4_err_cnt", 256'(err_cnt0), 256'(1));

        // R=1, len=0, last missing: one beat, error, two extra flits dropped
        exp_aw1.push_back(awx(4'd2, 4'd1, 2'd1, 3'd3, 8'd0, 32'h0000_5000));
        exp_w1.push_back({1'b1, 8'hff, tdat(50)});
        exp_aw1.push_back(awx(4'd7, 4'd9, 2'd1, 3'd3, 8'd1, 32'h0000_5100));
        exp_w1.push_back({1'b0, 8'h33, tdat(53)});
        exp_w1.push_back({1'b1, 8'hff, tdat(54)});
        send(1, hdr(4'd2, 4'd1, 2'd1, 3'd3, 8'd0, 32'h0000_5000));
        send(1, dat(1'b0, 8'hff, tdat(50)));
        send(1, dat(1'b0, 8'hff, tdat(51)));
        send(1, dat(1'b1, 8'hff, tdat(52)));
        send(1, hdr(4'd7, 4'd9, 2'd1, 3'd3, 8'd1, 32'h0000_5100));
        send(1, dat(1'b0, 8'h33, tdat(53)));
        send(1, dat(1'b1, 8'hff, tdat(54)));
        drain();
        chk("t5_err_cnt", 256'(err_cnt1), 256'(1));

        // reset mid-burst flushes both buffers without an error pulse
        awready0 = 1'b0; wready0 = 1'b0;
        send(0, hdr(4'd4, 4'd4, 2'd1, 3'd3, 8'd3, 32'h0000_6000));
        send(0, dat(1'b0, 8'hff, tdat(60)));
        send(0, dat(1'b0, 8'hff, tdat(61)));
        send(0, dat(1'b0, 8'hff, tdat(62)));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t6_awvalid_flushed", 256'(awvalid0), 256'(0));
        chk("t6_wvalid_flushed", 256'(wvalid0), 256'(0));
        chk("t6_fready_head", 256'(fready0), 256'(1));
        @(posedge clk); #1;
        awready0 = 1'b1; wready0 = 1'b1;
        exp_aw0.push_back(awx(4'd8, 4'd5, 2'd1, 3'd3, 8'd0, 32'h0000_7000));
        exp_w0.push_back({1'b1, 16'hffff, tdat(71), tdat(70)});
        send(0, hdr(4'd8, 4'd5, 2'd1, 3'd3, 8'd0, 32'h0000_7000));
        send(0, dat(1'b0, 8'hff, tdat(70)));
        send(0, dat(1'b1, 8'hff, tdat(71)));
        drain();
        chk("t6_err_cnt", 256'(err_cnt0), 256'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1);
    end

endmodule
